plot_port_arbiter: RTL and testbench

- Shares the single vga_adapter plot port (x, y, colour, plot) among up to NREQ pixel renderers: board/banner renderer, chip renderer, cursor, AI-hint overlay.
- Replaces the ad-hoc draw-flag mux in game with a request/grant handshake.
- Uses round-robin fairness and burst locking, so a renderer's sprite is never interleaved with another's.
- Sits between the renderers and vga_adapter.

---
 rtl/plot_arb_pkg.sv | 25 ++
 rtl/plot_port_arbiter_rr_pick.sv | 28 ++
 rtl/plot_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_plot_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_arb_pkg.sv
// Shared types and constants for the plot-port arbiter: FSM state, default
// widths, screen bounds and the packed-slice offset helper.
package plot_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_C_W      = 9;
    localparam int DEF_MAX_HOLD = 20000;

    localparam int SCREEN_X_MAX = 160;
    localparam int SCREEN_Y_MAX = 120;

    // Low bit of requester idx's field inside a packed per-requester bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/plot_port_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first requester at or after
// ptr, wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] pick_idx,
    output logic          any_valid
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[PW'((int'(ptr) + k) % N)]) begin
                pick     = N'(1) << ((int'(ptr) + k) % N);
                pick_idx = PW'((int'(ptr) + k) % N);
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/plot_port_arbiter.sv
// Round-robin, burst-locked arbiter sharing the vga_adapter plot port among
// NREQ renderers. Optional off-screen clipping is enabled by PLOT_CLIP_EN.
module plot_port_arbiter
    import plot_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int C_W      = DEF_C_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int X_MAX    = SCREEN_X_MAX,
    parameter int Y_MAX    = SCREEN_Y_MAX
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     px_valid,
    input  logic [NREQ-1:0]     px_last,
    input  logic [NREQ*X_W-1:0] x_in,
    input  logic [NREQ*Y_W-1:0] y_in,
    input  logic [NREQ*C_W-1:0] c_in,
    output logic [NREQ-1:0]     gnt,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [C_W-1:0]      colour,
    output logic                plot,
    output logic                busy,
    output logic                timeout,
    output logic                clip_drop
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    arb_state_t      state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   gnt_idx_reg;
    logic [HC_W-1:0] hold_cnt_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [X_W-1:0]  x_reg;
    logic [Y_W-1:0]  y_reg;
    logic [C_W-1:0]  c_reg;
    logic            plot_reg;
    logic            busy_reg;
    logic            timeout_reg;
    logic            clip_reg;

    logic [X_W-1:0] x_arr [NREQ];
    logic [Y_W-1:0] y_arr [NREQ];
    logic [C_W-1:0] c_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign x_arr[gi] = x_in[slice_lo(gi, X_W) +: X_W];
            assign y_arr[gi] = y_in[slice_lo(gi, Y_W) +: Y_W];
            assign c_arr[gi] = c_in[slice_lo(gi, C_W) +: C_W];
        end
    endgenerate

    logic [NREQ-1:0] pick;
    logic [PW-1:0]   pick_idx;
    logic            any_req;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req       (req),
        .ptr       (ptr_reg),
        .pick      (pick),
        .pick_idx  (pick_idx),
        .any_valid (any_req)
    );

    logic           sel_req;
    logic           sel_valid;
    logic           sel_last;
    logic [X_W-1:0] sel_x;
    logic [Y_W-1:0] sel_y;
    logic [C_W-1:0] sel_c;
    logic           px_take;
    logic           last_seen;
    logic           hold_expired;
    logic           burst_end;
    logic           px_in_range;

    assign sel_req   = req[gnt_idx_reg];
    assign sel_valid = px_valid[gnt_idx_reg];
    assign sel_last  = px_last[gnt_idx_reg];
    assign sel_x     = x_arr[gnt_idx_reg];
    assign sel_y     = y_arr[gnt_idx_reg];
    assign sel_c     = c_arr[gnt_idx_reg];

    // A pixel counts only while its owner still holds req high.
    assign px_take      = (state_reg == HOLD) && sel_req && sel_valid;
    assign last_seen    = sel_valid && sel_last;
    assign hold_expired = (hold_cnt_reg == HOLD_LAST);
    assign burst_end    = (state_reg == HOLD) && (last_seen || !sel_req || hold_expired);

`ifdef PLOT_CLIP_EN
    assign px_in_range = (int'(sel_x) < X_MAX) && (int'(sel_y) < Y_MAX);
`else
    assign px_in_range = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            gnt_idx_reg  <= '0;
            hold_cnt_reg <= '0;
            gnt_reg      <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            c_reg        <= '0;
            plot_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            clip_reg     <= 1'b0;
        end else begin
            plot_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            clip_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_reg    <= HOLD;
                        gnt_reg      <= pick;
                        gnt_idx_reg  <= pick_idx;
                        hold_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                HOLD: begin
                    hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    if (px_take) begin
                        if (px_in_range) begin
                            plot_reg <= 1'b1;
                            x_reg    <= sel_x;
                            y_reg    <= sel_y;
                            c_reg    <= sel_c;
                        end else begin
                            clip_reg <= 1'b1;
                        end
                    end
                    if (burst_end) begin
                        state_reg   <= GAP;
                        gnt_reg     <= '0;
                        busy_reg    <= 1'b0;
                        ptr_reg     <= (gnt_idx_reg == PW'(NREQ - 1)) ? '0 : gnt_idx_reg + 1'b1;
                        // Forced release only when nothing else ended the burst.
                        timeout_reg <= hold_expired && sel_req && !last_seen;
                    end
                end
                GAP: begin
                    state_reg    <= IDLE;
                    hold_cnt_reg <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign x         = x_reg;
    assign y         = y_reg;
    assign colour    = c_reg;
    assign plot      = plot_reg;
    assign busy      = busy_reg;
    assign timeout   = timeout_reg;
    assign clip_drop = clip_reg;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Randomized bench for plot_port_arbiter with a transaction-level reference
// model; directed scenarios pin the model with literal expectations.
module tb_plot_port_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 300;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req, pv, pl;
    logic [31:0] x_in;
    logic [27:0] y_in;
    logic [35:0] c_in;
    logic [3:0]  gnt;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  colour;
    logic        plot, busy, timeout, clip_drop;

    plot_port_arbiter #(.NREQ(N), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .resetn(resetn), .req(req), .px_valid(pv), .px_last(pl),
        .x_in(x_in), .y_in(y_in), .c_in(c_in), .gnt(gnt), .x(x), .y(y),
        .colour(colour), .plot(plot), .busy(busy), .timeout(timeout),
        .clip_drop(clip_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- requester agents ----------------
    int rem[N], blen[N], vprob[N], dropa[N], sent[N];
    int fx_q[$], fy_q[$];

    task automatic set_ag(input int i, input int r, input int bl, input int vp, input int da);
        rem[i] = r; blen[i] = bl; vprob[i] = vp; dropa[i] = da; sent[i] = 0;
    endtask

    initial begin
        logic [7:0] xv;
        logic [6:0] yv;
        logic [8:0] cv;
        req = '0; pv = '0; pl = '0; x_in = '0; y_in = '0; c_in = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                xv = 8'($urandom); yv = 7'($urandom); cv = 9'($urandom);
                if (rem[i] > 0 && (dropa[i] < 0 || sent[i] < dropa[i])) begin
                    req[i] = 1'b1;
                    if (gnt[i] && int'($urandom_range(0, 99)) < vprob[i]) begin
                        if (i == 0 && fx_q.size() > 0) begin
                            xv = 8'(fx_q.pop_front());
                            yv = 7'(fy_q.pop_front());
                        end
                        pv[i] = 1'b1;
                        pl[i] = (rem[i] == 1) || (blen[i] > 0 && rem[i] % blen[i] == 1);
                        rem[i]--; sent[i]++;
                    end else if (gnt[i]) begin
                        pv[i] = 1'b0; pl[i] = 1'($urandom);
                    end else begin
                        pv[i] = 1'($urandom); pl[i] = 1'($urandom);
                    end
                end else if (rem[i] > 0) begin
                    // Drop req with a pixel on the same cycle: it must be discarded.
                    req[i] = 1'b0; pv[i] = 1'b1; pl[i] = 1'b0; rem[i] = 0;
                end else begin
                    req[i] = 1'b0; pv[i] = 1'($urandom); pl[i] = 1'($urandom);
                end
                x_in[i*8 +: 8] = xv;
                y_in[i*7 +: 7] = yv;
                c_in[i*9 +: 9] = cv;
            end
        end
    end

    // ---------------- reference model ----------------
    int m_owner = -1, m_cool = 0, m_held = 0, m_ptr = 0;
    logic e_plot = 1'b0, e_to = 1'b0, e_clip = 1'b0;
    logic [7:0] e_x = '0;
    logic [6:0] e_y = '0;
    logic [8:0] e_c = '0;

    task automatic model_step();
        int o;
        logic [7:0] sx;
        logic [6:0] sy;
        logic ok, lastp;
        e_plot = 1'b0; e_to = 1'b0; e_clip = 1'b0;
        if (!resetn) begin
            m_owner = -1; m_cool = 0; m_held = 0; m_ptr = 0;
        end else if (m_owner >= 0) begin
            o = m_owner;
            sx = x_in[o*8 +: 8];
            sy = y_in[o*7 +: 7];
            if (req[o] && pv[o]) begin
`ifdef PLOT_CLIP_EN
                ok = (sx < 8'd160) && (sy < 7'd120);
`else
                ok = 1'b1;
`endif
                if (ok) begin
                    e_plot = 1'b1; e_x = sx; e_y = sy; e_c = c_in[o*9 +: 9];
                end else begin
                    e_clip = 1'b1;
                end
            end
            lastp = pv[o] && pl[o];
            if (lastp || !req[o] || m_held == MAXH - 1) begin
                e_to = !lastp && req[o] && (m_held == MAXH - 1);
                m_ptr = (o + 1) % N;
                m_owner = -1;
                m_cool = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_held = 0;
                end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- monitor statistics ----------------
    int order_q[$], gap_q[$], len_q[$];
    int plots[N];
    int to_cnt, to_bad, clip_cnt, zero_run, cur_len, last_own;
    logic [3:0] prev_g;
    logic seen_burst;
    logic [7:0] last_x;
    logic [6:0] last_y;

    function automatic int oh_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_mon();
        order_q.delete(); gap_q.delete(); len_q.delete();
        for (int i = 0; i < N; i++) plots[i] = 0;
        to_cnt = 0; to_bad = 0; clip_cnt = 0; zero_run = 0; cur_len = 0;
        last_own = -1; seen_burst = 1'b0; prev_g = '0; last_x = '0; last_y = '0;
    endtask

    initial begin
        clear_mon();
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("gnt", 32'(gnt), (m_owner >= 0) ? 32'(4'b1 << m_owner) : 32'd0);
            chk("busy", 32'(busy), 32'(m_owner >= 0));
            chk("plot", 32'(plot), 32'(e_plot));
            chk("timeout", 32'(timeout), 32'(e_to));
            chk("clip_drop", 32'(clip_drop), 32'(e_clip));
            if (e_plot) begin
                chk("x", 32'(x), 32'(e_x));
                chk("y", 32'(y), 32'(e_y));
                chk("colour", 32'(colour), 32'(e_c));
            end
            if (gnt != '0) begin
                if (prev_g == '0) begin
                    order_q.push_back(oh_idx(gnt));
                    if (seen_burst) gap_q.push_back(zero_run);
                    cur_len = 0; last_own = oh_idx(gnt); seen_burst = 1'b1;
                end
                cur_len++;
            end else begin
                if (prev_g != '0) begin
                    len_q.push_back(cur_len);
                    zero_run = 0;
                end
                zero_run++;
            end
            if (plot && last_own >= 0) begin
                plots[last_own]++; last_x = x; last_y = y;
            end
            if (timeout) begin
                to_cnt++;
                if (!(prev_g != '0 && gnt == '0)) to_bad++;
            end
            if (clip_drop) clip_cnt++;
            prev_g = gnt;
        end
    end

    // ---------------- scenario control ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        clear_mon();
    endtask

    task automatic wait_idle(input int budget);
        int run = 0;
        for (int c = 0; c < budget; c++) begin
            tick(1);
            if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0 && gnt == '0) run++;
            else run = 0;
            if (run >= 4) return;
        end
        chk("wait_idle_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int gbad;
        int found;
        for (int i = 0; i < N; i++) set_ag(i, 0, 0, 100, -1);
        tick(3);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        resetn = 1'b1;
        clear_mon();

        // Requester 1 alone, 256-pixel burst.
        set_ag(1, 256, 0, 100, -1);
        wait_idle(2000);
        chk("s1_bursts", order_q.size(), 1);
        chk("s1_owner", qget(order_q, 0), 1);
        chk("s1_len", qget(len_q, 0), 256);
        chk("s1_plots", plots[1], 256);

        // All four requesting from reset, 4-pixel bursts.
        for (int i = 0; i < N; i++) set_ag(i, 12, 4, 100, -1);
        do_reset();
        wait_idle(2000);
        chk("s2_bursts", order_q.size(), 12);
        for (int k = 0; k < 12; k++) chk("s2_order", qget(order_q, k), k % 4);
        gbad = 0;
        foreach (gap_q[k]) if (gap_q[k] != 2) gbad++;
        chk("s2_gaps_n", gap_q.size(), 11);
        chk("s2_gaps_2", gbad, 0);

        // Requester 2 drops req after 10 of 20 pixels; requester 3 waiting.
        set_ag(2, 20, 0, 100, 10);
        set_ag(3, 4, 0, 100, -1);
        do_reset();
        wait_idle(2000);
        chk("s3_first", qget(order_q, 0), 2);
        chk("s3_next", qget(order_q, 1), 3);
        chk("s3_plots2", plots[2], 10);
        chk("s3_len2", qget(len_q, 0), 11);
        chk("s3_plots3", plots[3], 4);

        // Requester 0 never sends px_last: forced release after MAXH cycles.
        set_ag(0, 1000, 0, 50, -1);
        set_ag(1, 3, 0, 100, -1);
        do_reset();
        found = 0;
        for (int c = 0; c < 1000 && found == 0; c++) begin
            tick(1);
            if (order_q.size() >= 2) found = 1;
        end
        chk("s4_second_grant_seen", found, 1);
        rem[0] = 0;
        wait_idle(2000);
        chk("s4_first", qget(order_q, 0), 0);
        chk("s4_next", qget(order_q, 1), 1);
        chk("s4_len", qget(len_q, 0), MAXH);
        chk("s4_to_cnt", to_cnt, 1);
        chk("s4_to_in_gap", to_bad, 0);

        // Reset asserted for one cycle in the middle of requester 3's burst.
        set_ag(3, 50, 0, 100, -1);
        do_reset();
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            tick(1);
            if (gnt == 4'b1000) found = 1;
        end
        chk("s5_grant3_seen", found, 1);
        tick(5);
        set_ag(1, 5, 0, 100, -1);
        resetn = 1'b0;
        tick(1);
        chk("s5_gnt", 32'(gnt), 32'd0);
        chk("s5_plot", 32'(plot), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        clear_mon();
        wait_idle(2000);
        chk("s5_rearb_first", qget(order_q, 0), 1);
        chk("s5_rearb_next", qget(order_q, 1), 3);

        // Directed edge pixels (160,5) then (159,119).
        set_ag(0, 2, 0, 100, -1);
        fx_q = '{160, 159};
        fy_q = '{5, 119};
        clear_mon();
        wait_idle(500);
`ifdef PLOT_CLIP_EN
        chk("clip_cnt", clip_cnt, 1);
        chk("clip_plots", plots[0], 1);
`else
        chk("clip_cnt", clip_cnt, 0);
        chk("clip_plots", plots[0], 2);
`endif
        chk("clip_last_x", 32'(last_x), 32'd159);
        chk("clip_last_y", 32'(last_y), 32'd119);

        // Randomized traffic against the model.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++)
                set_ag(i, $urandom_range(0, 30), $urandom_range(0, 6), $urandom_range(30, 100),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1);
            if (r % 7 == 0) do_reset();
            wait_idle(3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_time_limit got=running want=finished");
        $fatal(1, "time limit");
    end

endmodule
